// File: rtl/ysyx_22040237_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_22040237_ifu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22040237_pc_reg.sv
// Architectural PC: reset load, sequential +4, redirect load with low bits
// cleared, and a one-cycle pulse flagging misaligned redirect targets.
module ysyx_22040237_pc_reg #(
  parameter int                 ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              misalign
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      // redirect wins over sequential advance
      if (redirect_valid)
        pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (inc)
        pc <= pc + ADDR_W'(4);
    end
  end

endmodule

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: one outstanding imem fetch, one-entry buffer to IDU.
// Define YSYX_22040237_IFU_PERF_CNT_EN to add fetch/flush counters.
module ysyx_22040237_ifu
  import ysyx_22040237_ifu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_resp_valid_i,
  input  logic [INST_W-1:0] imem_resp_data_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              misalign_o
`ifdef YSYX_22040237_IFU_PERF_CNT_EN
  ,
  output logic [63:0]       fetch_cnt_o,
  output logic [63:0]       flush_cnt_o
`endif
);

  ifu_state_t        state, state_n;
  logic              kill, kill_n;
  logic              capture, flush;
  logic [ADDR_W-1:0] pc;

  ysyx_22040237_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .inc            (state == S_HOLD && inst_ready_i),
    .redirect_valid (redirect_valid_i),
    .redirect_pc    (redirect_pc_i),
    .pc             (pc),
    .misalign       (misalign_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      kill  <= 1'b0;
    end else begin
      state <= state_n;
      kill  <= kill_n;
    end
  end

  always_comb begin
    state_n = state;
    kill_n  = kill;
    capture = 1'b0;
    flush   = 1'b0;
    case (state)
      S_REQ: begin
        // a redirect racing the acceptance poisons the fetch just issued
        if (imem_req_ready_i) begin
          state_n = S_WAIT;
          kill_n  = redirect_valid_i;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid_i) begin
          kill_n  = 1'b0;
          flush   = kill || redirect_valid_i;
          capture = !flush;
          state_n = flush ? S_REQ : S_HOLD;
        end else if (redirect_valid_i) begin
          kill_n = 1'b1;
        end
      end
      S_HOLD: begin
        flush = redirect_valid_i;
        if (redirect_valid_i || inst_ready_i) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_o <= INST_W'(NOP);
      pc_o   <= '0;
    end else if (capture) begin
      inst_o <= imem_resp_data_i;
      pc_o   <= pc;
    end
  end

  assign imem_req_valid_o = (state == S_REQ);
  assign imem_req_addr_o  = pc;
  assign inst_valid_o     = (state == S_HOLD);

`ifdef YSYX_22040237_IFU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (inst_valid_o && inst_ready_i && !(&fetch_cnt_o))
        fetch_cnt_o <= fetch_cnt_o + 64'd1;
      if (flush && !(&flush_cnt_o))
        flush_cnt_o <= flush_cnt_o + 64'd1;
    end
  end
`endif

  // only one fetch may be outstanding; a response is legal only while waiting
  a_resp_in_wait: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid_i |-> state == S_WAIT);

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Randomized bench: transaction-level model of the fetch protocol and PC rules.
module tb_ysyx_22040237_ifu;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0, rst;
  logic        imem_req_valid_o, imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        inst_valid_o, inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        misalign_o;

  always #5 clk = ~clk;

  ysyx_22040237_ifu #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_resp_valid_i(imem_resp_valid_i), .imem_resp_data_i(imem_resp_data_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .pc_o(pc_o), .misalign_o(misalign_o)
  );

  int ncheck = 0, npass = 0, cyc = 0, ndel = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncheck++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  // model: architectural pc, outstanding fetch, buffered instruction
  logic [63:0] mpc, acc_addr, s;
  bit          pend, dirty, exp_vld, exp_mis, force_r;
  logic [63:0] force_t;
  int          resp_at;
  int          p_mrdy, p_idu, p_redir, dmin, dmax;

  function automatic logic [31:0] memw(input logic [63:0] a);
    if (a == RPC) return 32'h0000_0513;
    return a[31:0] ^ a[63:32] ^ 32'h3c5a_0013;
  endfunction

  function automatic logic [63:0] pick_tgt();
    case ($urandom_range(3))
      0: return RPC + 64'({$urandom_range(255), 2'b00}) + 64'($urandom_range(3));
      1: return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
      2: return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic model_reset();
    mpc = RPC; pend = 0; dirty = 0; exp_vld = 0; exp_mis = 0; force_r = 0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_inst_valid", inst_valid_o, 0);
    chk("rst_inst", inst_o, 32'h0000_0013);
    chk("rst_pc_o", pc_o, 0);
    chk("rst_misalign", misalign_o, 0);
    chk("rst_req_valid", imem_req_valid_o, 1);
    chk("rst_req_addr", imem_req_addr_o, RPC);
  endtask

  // called at a negedge: check state, drive inputs, advance model, wait a cycle
  task automatic step();
    bit acc, hs, rv, cur_vld, rd;
    chk("req_valid", imem_req_valid_o, !pend && !exp_vld);
    chk("req_addr", imem_req_addr_o, mpc);
    chk("inst_valid", inst_valid_o, exp_vld);
    if (exp_vld) begin
      chk("pc_o", pc_o, mpc);
      chk("inst_o", inst_o, memw(mpc));
    end
    chk("misalign", misalign_o, exp_mis);

    imem_req_ready_i = ($urandom_range(99) < p_mrdy);
    inst_ready_i     = ($urandom_range(99) < p_idu);
    if (force_r) begin
      rd = 1; redirect_pc_i = force_t; force_r = 0;
    end else begin
      rd = ($urandom_range(99) < p_redir); redirect_pc_i = pick_tgt();
    end
    redirect_valid_i  = rd;
    rv                = pend && resp_at == cyc;
    imem_resp_valid_i = rv;
    imem_resp_data_i  = rv ? ((dirty || rd) ? 32'hDEAD_BEEF : memw(acc_addr)) : $urandom;

    cur_vld = exp_vld;
    acc = !pend && !exp_vld && imem_req_ready_i;
    hs  = exp_vld && inst_ready_i;
    if (hs) ndel++;
    if (rv) begin
      pend = 0; exp_vld = !(dirty || rd);
    end else if (pend && rd) dirty = 1;
    if (cur_vld && (inst_ready_i || rd)) exp_vld = 0;
    if (acc) begin
      pend = 1; dirty = rd; acc_addr = mpc;
      resp_at = cyc + $urandom_range(dmax, dmin);
    end
    exp_mis = rd && redirect_pc_i[1:0] != 2'b00;
    if (rd) mpc = {redirect_pc_i[63:2], 2'b00};
    else if (hs) mpc = mpc + 64'd4;
    cyc++;
    @(negedge clk);
  endtask

  // kind 0: request phase, 1: instruction held, 2: fetch outstanding
  task automatic run_until(input int kind);
    for (int i = 0; i < 50; i++) begin
      if ((kind == 0 && !pend && !exp_vld) || (kind == 1 && exp_vld) || (kind == 2 && pend))
        return;
      step();
    end
    chk("run_until_timeout", 0, 1);
  endtask

  initial begin
    rst = 1; imem_req_ready_i = 0; imem_resp_valid_i = 0; imem_resp_data_i = 0;
    redirect_valid_i = 0; redirect_pc_i = 0; inst_ready_i = 0;
    model_reset();
    p_mrdy = 100; p_idu = 100; p_redir = 0; dmin = 1; dmax = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    chk_reset_vals();

    // first fetch: accept c0, respond c1, deliver c2
    step(); step();
    chk("first_vld", inst_valid_o, 1);
    chk("first_inst", inst_o, 32'h0000_0513);
    chk("first_pc", pc_o, RPC);
    step();
    chk("second_addr", imem_req_addr_o, RPC + 64'd4);

    // IDU stall in HOLD
    p_idu = 0;
    run_until(1);
    repeat (5) begin
      chk("stall_no_req", imem_req_valid_o, 0);
      step();
    end
    s = mpc; p_idu = 100;
    step();
    chk("after_stall_addr", imem_req_addr_o, s + 64'd4);

    // redirect while waiting, late response is discarded
    run_until(0);
    dmin = 2; dmax = 2;
    step();
    force_r = 1; force_t = 64'h8000_1000;
    step(); step();
    chk("wait_redir_vld", inst_valid_o, 0);
    chk("wait_redir_addr", imem_req_addr_o, 64'h8000_1000);

    // redirect in HOLD with ready: drop, no pc+4
    dmin = 1; dmax = 1;
    run_until(1);
    force_r = 1; force_t = 64'h8000_2000;
    step();
    chk("hold_redir_addr", imem_req_addr_o, 64'h8000_2000);
    chk("hold_redir_vld", inst_valid_o, 0);

    // misaligned target
    force_r = 1; force_t = 64'h8000_3002;
    step();
    chk("mis_pulse", misalign_o, 1);
    chk("mis_addr", imem_req_addr_o, 64'h8000_3000);
    step();
    chk("mis_once", misalign_o, 0);

    // pc wrap
    run_until(0);
    force_r = 1; force_t = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    run_until(1);
    step();
    chk("wrap_addr", imem_req_addr_o, 64'h0);

    // randomized traffic
    p_mrdy = 60; p_idu = 60; p_redir = 10; dmin = 1; dmax = 3;
    repeat (1500) step();

    // asynchronous reset with a fetch outstanding
    run_until(2);
    #2 rst = 1;
    #1 chk_reset_vals();
    imem_resp_valid_i = 0; redirect_valid_i = 0;
    @(negedge clk); rst = 0;
    model_reset();
    repeat (1500) step();
    chk("deliveries_seen", ndel > 100, 1);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end
endmodule

// File: doc/ysyx_22040237_ifu.md
Name: ysyx_22040237_ifu

Overview:
- Instruction fetch unit: the producer end of the decoder's instruction/PC input interface.
- Holds the architectural PC and issues word fetches to instruction memory over a valid/ready request and a valid-only response.
- Buffers one instruction and presents it with its PC to the IDU over a valid/ready handshake.
- Accepts a redirect (taken branch/jump target) from the EXU and discards stale in-flight fetches.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- ADDR_W, 64, PC/fetch address width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts request this cycle.
- imem_req_addr_o  out  ADDR_W  fetch address; always equals current pc.
- imem_resp_valid_i  in  1  response data valid; at most one per accepted request, no earlier than the cycle after acceptance.
- imem_resp_data_i  in  INST_W  fetched instruction word.
- redirect_valid_i  in  1  EXU redirect request.
- redirect_pc_i  in  ADDR_W  redirect target.
- inst_valid_o  out  1  inst_o/pc_o valid toward the IDU.
- inst_ready_i  in  1  IDU consumes the instruction.
- inst_o  out  INST_W  buffered instruction.
- pc_o  out  ADDR_W  PC of inst_o.
- misalign_o  out  1  one-cycle pulse: redirect target had bits [1:0] != 0.

Behaviour:
- Reset values: state=S_REQ, pc=RESET_PC, kill=0, inst_valid_o=0, inst_o=32'h0000_0013 (NOP), pc_o=0, misalign_o=0. imem_req_valid_o=1 in the first cycle after reset release.
- S_REQ: imem_req_valid_o=1, imem_req_addr_o=pc.
  - req_ready=1 -> S_WAIT.
  - A redirect in the same cycle as acceptance still goes to S_WAIT, but with kill=1 and pc<=target.
  - A redirect without acceptance sets pc<=target and stays in S_REQ. The address changes next cycle; the request is not held stable across a redirect.
- S_WAIT: imem_req_valid_o=0.
  - Response with kill=0 and no redirect: inst_o<=data, pc_o<=pc, inst_valid_o<=1, -> S_HOLD.
  - Response with kill=1, or with a same-cycle redirect: data discarded, kill<=0, -> S_REQ.
  - A redirect with no response: kill<=1, pc<=target, stay in S_WAIT.
- S_HOLD: inst_valid_o=1; inst_o/pc_o stay stable until the handshake completes.
  - inst_ready_i=1 and no redirect: pc<=pc+4, inst_valid_o<=0, -> S_REQ.
  - Redirect (with or without ready): pc<=target, inst_valid_o<=0, -> S_REQ. Redirect has priority over pc+4.
- PC arithmetic: pc+4 is modulo 2^ADDR_W, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Redirect target bits [1:0] are forced to 0 when loaded. misalign_o pulses the cycle after any redirect with a non-zero low field.
- Latency:
  - First fetch: request issued in cycle 0.
  - A response in cycle N gives inst_valid_o=1 in cycle N+1.
  - Back-to-back throughput is 1 instruction per 3 cycles, given single-cycle memory and an always-ready IDU.
- At most one outstanding fetch. A response in S_REQ or S_HOLD is a protocol violation; it is ignored, and an assertion flags it in simulation.
- Reset mid-transaction returns all state to the reset values immediately. Any response arriving after reset release while in S_REQ is ignored.

Optional Feature:
- Macro: YSYX_22040237_IFU_PERF_CNT_EN.
- Defined: adds 64-bit counters fetch_cnt_o (instructions delivered, i.e. inst_valid_o&inst_ready_i) and flush_cnt_o (fetches discarded by kill or HOLD redirect), both reset to 0 and saturating at all-ones. Both are exposed as output ports.
- Undefined: neither the ports nor the counters exist, and the behaviour is otherwise identical.

Decomposition:
- Package ysyx_22040237_ifu_pkg holds:
  - state enum (S_REQ, S_WAIT, S_HOLD), 2-bit encoding;
  - NOP constant 32'h0000_0013;
  - default RESET_PC.
- One natural sub-module, ysyx_22040237_pc_reg: the pc register with reset load, +4 increment, redirect load and low-bit masking, plus misalign pulse generation. The FSM and instruction buffer stay in the top.

Test Plan:
- Reset release, memory ready, 1-cycle response 32'h0000_0513, IDU ready -> first req addr 0x80000000; inst_valid_o with inst_o=0x00000513, pc_o=0x80000000; next req addr 0x80000004.
- IDU holds inst_ready_i=0 for 5 cycles in S_HOLD -> inst_o/pc_o stable, no new request. Ready asserted -> next req addr pc+4.
- Redirect to 0x80001000 in S_WAIT, then response 0xDEADBEEF arrives -> response discarded, inst_valid_o stays 0, next req addr 0x80001000.
- Redirect to 0x80002000 in S_HOLD with inst_ready_i=1 -> instruction dropped, next req addr 0x80002000 (not pc+4).
- Redirect to 0x80003002 -> misalign_o pulses once, next req addr 0x80003000.
- Set pc to 0xFFFF_FFFF_FFFF_FFFC via redirect, complete the handshake -> next req addr 0. With the perf macro defined, fetch_cnt_o and flush_cnt_o match the counts of delivered and discarded fetches.
